// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port backing memory between the instruction-fetch
//   requester and the data-memory requester. One transaction is in flight
//   at a time: IDLE (arbitrate + latch) -> ISSUE (mem_req pulse) -> WAIT
//   (collect mem_rvalid or time out) -> RESP (valid pulse to owner).
//   Data normally wins; a starvation counter forces fetch after
//   STARVE_LIMIT consecutive data grants made while fetch was waiting.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_valid)
//   if_rdata/if_valid   registered fetch data + one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (held until d_valid)
//   d_rdata/d_valid     registered load data + one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  backing memory request side
//   mem_rdata/mem_rvalid               backing memory response side
//   busy                high whenever the FSM is not IDLE
//   err                 sticky timeout flag, cleared only by reset
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic            own_d;       // 1 = current transaction belongs to data port
  logic [SW-1:0]   starve_cnt;
  logic [WW-1:0]   wait_cnt;

  logic starve_hit, grant_if, grant_d;

  always_comb begin
    starve_hit = (starve_cnt == STARVE_MAX);
    grant_if   = if_req & (~d_req | starve_hit);
    grant_d    = d_req & ~grant_if;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      own_d      <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      mem_req  <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= ISSUE;
            mem_req   <= 1'b1;
            own_d     <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Only data grants that bypass a waiting fetch count as starvation.
            if (if_req && !starve_hit) starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_if) begin
            state      <= ISSUE;
            mem_req    <= 1'b1;
            own_d      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= RESP;
            if (own_d) begin
              d_valid <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Memory went silent: complete with zero data and flag it.
            state <= RESP;
            err   <= 1'b1;
            if (own_d) begin
              d_valid <= 1'b1;
              if (!mem_we) d_rdata <= '0;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        // No arbitration here: the owner still holds its request this cycle.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        busy;
  logic        err;

  logic        auto_en = 1'b0;
  logic        auto_rv = 1'b0;
  logic        man_rv  = 1'b0;
  logic        pend    = 1'b0;
  logic [31:0] rdata_val = 32'h0;

  int checks = 0;
  int errors = 0;

  assign mem_rvalid = auto_rv | man_rv;
  assign mem_rdata  = rdata_val;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: answers one cycle after each mem_req when enabled.
  always begin
    @(posedge clk);
    #1;
    auto_rv = auto_en & pend;
    pend    = mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick(); tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ifv", 32'(if_valid), 0);
    chk("rst_dv", 32'(d_valid), 0);
    chk("rst_mreq", 32'(mem_req), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_ifrd", if_rdata, 0);
    chk("rst_drd", d_rdata, 0);
    reset = 1'b0;
    tick();

    // Fetch only
    auto_en = 1'b1; rdata_val = 32'h00500093;
    if_req = 1'b1; if_addr = 32'h40;
    tick();  // c1
    chk("f_mreq", 32'(mem_req), 1);
    chk("f_maddr", mem_addr, 32'h40);
    chk("f_mwe", 32'(mem_we), 0);
    chk("f_busy1", 32'(busy), 1);
    tick();  // c2
    chk("f_mreq_c2", 32'(mem_req), 0);
    chk("f_busy2", 32'(busy), 1);
    chk("f_ifv_c2", 32'(if_valid), 0);
    tick();  // c3
    chk("f_ifv", 32'(if_valid), 1);
    chk("f_ifrd", if_rdata, 32'h00500093);
    chk("f_busy3", 32'(busy), 1);
    if_req = 1'b0;
    tick();  // c4
    chk("f_ifv_c4", 32'(if_valid), 0);
    chk("f_busy4", 32'(busy), 0);

    // Both at once: store wins, then fetch
    rdata_val = 32'h11111111;
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFEF00D;
    tick();  // c1
    chk("b_mreq", 32'(mem_req), 1);
    chk("b_mwe", 32'(mem_we), 1);
    chk("b_maddr", mem_addr, 32'h100);
    chk("b_mwdata", mem_wdata, 32'hCAFEF00D);
    tick(); tick();  // c3
    chk("b_dv", 32'(d_valid), 1);
    chk("b_ifv_c3", 32'(if_valid), 0);
    chk("b_drd", d_rdata, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    tick();  // c4
    chk("b_mreq_c4", 32'(mem_req), 0);
    rdata_val = 32'h22222222;
    tick();  // c5
    chk("b_f_mreq", 32'(mem_req), 1);
    chk("b_f_maddr", mem_addr, 32'h44);
    chk("b_f_mwe", 32'(mem_we), 0);
    tick(); tick();  // c7
    chk("b_ifv", 32'(if_valid), 1);
    chk("b_dv_c7", 32'(d_valid), 0);
    chk("b_ifrd", if_rdata, 32'h22222222);
    if_req = 1'b0;
    tick();
    chk("b_busy", 32'(busy), 0);

    // Starvation: 4 data grants, 5th to fetch, 6th back to data
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      rdata_val = 32'h30000000 + 32'(g);
      tick();  // ISSUE
      chk($sformatf("s_mreq%0d", g), 32'(mem_req), 1);
      chk($sformatf("s_maddr%0d", g), mem_addr, (g == 4) ? 32'h80 : 32'h200);
      tick(); tick();  // RESP
      if (g == 4) begin
        chk("s_ifv4", 32'(if_valid), 1);
        chk("s_ifrd4", if_rdata, 32'h30000004);
      end else begin
        chk($sformatf("s_dv%0d", g), 32'(d_valid), 1);
        chk($sformatf("s_drd%0d", g), d_rdata, 32'h30000000 + 32'(g));
      end
      if (g == 5) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      tick();  // IDLE
    end
    chk("s_busy", 32'(busy), 0);

    // Timeout on a load
    auto_en = 1'b0; rdata_val = 32'hDEADBEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();  // c1
    chk("t_mreq", 32'(mem_req), 1);
    for (int c = 2; c <= 17; c++) tick();  // c17
    chk("t_dv_c17", 32'(d_valid), 0);
    chk("t_err_c17", 32'(err), 0);
    tick();  // c18
    chk("t_dv", 32'(d_valid), 1);
    chk("t_drd", d_rdata, 32'h0);
    chk("t_err", 32'(err), 1);
    d_req = 1'b0;
    tick();  // c19
    chk("t_busy", 32'(busy), 0);
    man_rv = 1'b1;
    tick();  // c20
    man_rv = 1'b0;
    chk("t_stray_dv", 32'(d_valid), 0);
    chk("t_stray_ifv", 32'(if_valid), 0);
    chk("t_stray_busy", 32'(busy), 0);
    chk("t_stray_drd", d_rdata, 32'h0);
    chk("t_err_sticky", 32'(err), 1);

    // Reset during WAIT, stray response afterwards
    if_req = 1'b1; if_addr = 32'h500;
    tick(); tick(); tick();  // c3, in WAIT
    chk("r_busy_wait", 32'(busy), 1);
    reset = 1'b1;
    tick();  // c4
    reset = 1'b0; if_req = 1'b0;
    chk("r_busy", 32'(busy), 0);
    chk("r_err", 32'(err), 0);
    chk("r_maddr", mem_addr, 0);
    chk("r_ifv", 32'(if_valid), 0);
    man_rv = 1'b1;
    tick();  // c5
    man_rv = 1'b0;
    chk("r_stray_ifv", 32'(if_valid), 0);
    chk("r_stray_busy", 32'(busy), 0);
    chk("r_ifrd", if_rdata, 0);
    auto_en = 1'b1; rdata_val = 32'h0A0A0A0A;
    if_req = 1'b1; if_addr = 32'h600;
    tick();
    chk("r_f_maddr", mem_addr, 32'h600);
    tick(); tick();
    chk("r_f_ifv", 32'(if_valid), 1);
    chk("r_f_ifrd", if_rdata, 32'h0A0A0A0A);
    if_req = 1'b0;
    tick();

    // Request held through the valid cycle must not reissue from RESP
    rdata_val = 32'h77777777;
    if_req = 1'b1; if_addr = 32'h700;
    tick();  // c1
    chk("h_mreq", 32'(mem_req), 1);
    tick(); tick();  // c3, if_req still high
    chk("h_ifv", 32'(if_valid), 1);
    tick();  // c4
    chk("h_mreq_c4", 32'(mem_req), 0);
    chk("h_busy_c4", 32'(busy), 0);
    if_req = 1'b0;
    tick();  // c5
    chk("h_mreq_c5", 32'(mem_req), 0);
    chk("h_busy_c5", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
